branch_seq: RTL and testbench



---
 rtl/branch_seq.sv | 150 +++++++++++++++
 tb/tb_branch_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_seq.sv
// branch_seq: multi-cycle RV32I conditional-branch resolution sequencer.
// Accepts one branch at a time, evaluates it on registered operands, raises a
// redirect for taken branches, then holds a flush window. Saturating
// taken/not-taken counters are kept for performance inspection.
module branch_seq #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       fu_3,
  input  logic [31:0]      op1,
  input  logic [31:0]      op2,
  input  logic [31:0]      pc,
  input  logic [31:0]      imm,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             illegal,
  output logic             misalign,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_REDIR,
    S_FLUSH
  } state_t;

  // Flush counter is loaded with the last index so it runs FLUSH_CYCLES cycles.
  localparam logic [3:0] FLUSH_LAST =
    (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  fu3_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [31:0] pc_q;
  logic [31:0] imm_q;
  logic [3:0]  fcnt;
  logic        cond;
  logic        legal;
  logic        is_mis;
  logic        is_taken;
  logic [31:0] target;
  logic        accept;

  assign br_ready = (state == S_IDLE);
  assign accept   = br_ready & br_valid;
  assign legal    = (fu3_q[2:1] != 2'b01);
  assign target   = pc_q + imm_q;
  assign is_mis   = legal & cond & (target[1:0] != 2'b00);
  assign is_taken = legal & cond & ~is_mis;

  // Branch condition evaluated on the registered operands.
  always_comb begin
    cond = 1'b0;
    case (fu3_q)
      3'b000:  cond = (op1_q == op2_q);
      3'b001:  cond = (op1_q != op2_q);
      3'b100:  cond = ($signed(op1_q) <  $signed(op2_q));
      3'b101:  cond = ($signed(op1_q) >= $signed(op2_q));
      3'b110:  cond = (op1_q <  op2_q);
      3'b111:  cond = (op1_q >= op2_q);
      default: cond = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (br_valid) state_nx = S_EVAL;
      S_EVAL:  state_nx = is_taken ? S_REDIR : S_IDLE;
      S_REDIR: begin
        if (redirect_ready) state_nx = (FLUSH_CYCLES == 0) ? S_IDLE : S_FLUSH;
      end
      S_FLUSH: if (fcnt == 4'd0) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Capture the request operands on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      fu3_q <= fu_3;
      op1_q <= op1;
      op2_q <= op2;
      pc_q  <= pc;
      imm_q <= imm;
    end
  end

  // Flush window countdown.
  always_ff @(posedge clk) begin
    if (!rst_n)                                        fcnt <= 4'd0;
    else if (state_nx == S_FLUSH && state != S_FLUSH)  fcnt <= FLUSH_LAST;
    else if (state == S_FLUSH)                         fcnt <= fcnt - 4'd1;
  end

  // Registered resolve, redirect and flush outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resolve_valid  <= 1'b0;
      resolve_taken  <= 1'b0;
      illegal        <= 1'b0;
      misalign       <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
    end else begin
      resolve_valid  <= (state == S_EVAL);
      resolve_taken  <= (state == S_EVAL) & is_taken;
      illegal        <= (state == S_EVAL) & ~legal;
      misalign       <= (state == S_EVAL) & is_mis;
      redirect_valid <= (state_nx == S_REDIR);
      flush          <= (state_nx == S_FLUSH);
      if (state == S_EVAL && is_taken) redirect_pc <= target;
    end
  end

  // Saturating statistics counters, advanced on each resolve pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_cnt <= '0;
      nt_cnt    <= '0;
    end else if (resolve_valid) begin
      if (resolve_taken) begin
        if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
      end else begin
        if (nt_cnt != '1) nt_cnt <= nt_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: three branch_seq instances (default, CNT_W=2, FLUSH_CYCLES=0)
// share one stimulus stream; each is checked every cycle against a
// timeline-based reference model of the branch sequencer behaviour.
module tb_branch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_valid;
  logic [2:0]  fu_3;
  logic [31:0] op1, op2, pc, imm;
  logic        redirect_ready;

  logic [2:0]  rdy_o, rv_o, rt_o, ill_o, mis_o, rdv_o, fl_o;
  logic [31:0] rpc0, rpc1, rpc2;
  logic [15:0] tc0, nc0, tc2, nc2;
  logic [1:0]  tc1, nc1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_seq #(.FLUSH_CYCLES(2), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(rdy_o[0]),
    .fu_3(fu_3), .op1(op1), .op2(op2), .pc(pc), .imm(imm),
    .resolve_valid(rv_o[0]), .resolve_taken(rt_o[0]), .illegal(ill_o[0]),
    .misalign(mis_o[0]), .redirect_valid(rdv_o[0]), .redirect_pc(rpc0),
    .redirect_ready(redirect_ready), .flush(fl_o[0]),
    .taken_cnt(tc0), .nt_cnt(nc0));

  branch_seq #(.FLUSH_CYCLES(2), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(rdy_o[1]),
    .fu_3(fu_3), .op1(op1), .op2(op2), .pc(pc), .imm(imm),
    .resolve_valid(rv_o[1]), .resolve_taken(rt_o[1]), .illegal(ill_o[1]),
    .misalign(mis_o[1]), .redirect_valid(rdv_o[1]), .redirect_pc(rpc1),
    .redirect_ready(redirect_ready), .flush(fl_o[1]),
    .taken_cnt(tc1), .nt_cnt(nc1));

  branch_seq #(.FLUSH_CYCLES(0), .CNT_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(rdy_o[2]),
    .fu_3(fu_3), .op1(op1), .op2(op2), .pc(pc), .imm(imm),
    .resolve_valid(rv_o[2]), .resolve_taken(rt_o[2]), .illegal(ill_o[2]),
    .misalign(mis_o[2]), .redirect_valid(rdv_o[2]), .redirect_pc(rpc2),
    .redirect_ready(redirect_ready), .flush(fl_o[2]),
    .taken_cnt(tc2), .nt_cnt(nc2));

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-instance timeline of expected events.
  int          flush_len[3] = '{2, 2, 0};
  int          cnt_max[3]   = '{65535, 3, 65535};
  bit          m_redir[3];
  int          m_fl[3];
  int          m_res[3];
  int          m_idle[3];
  bit          e_tk[3], e_il[3], e_mi[3];
  logic [31:0] e_tgt[3], m_rpc[3];
  int          m_tc[3], m_nc[3];
  bit          model_on = 1'b0;
  int          cyc = 0;

  function automatic bit model_ready(input int k, input int c);
    return !m_redir[k] && m_fl[k] == 0 && c >= m_idle[k];
  endfunction

  task automatic model_step(input int k, input int c);
    bit          rdy_now, cnd, lgl;
    logic [31:0] t;
    if (!rst_n) begin
      m_redir[k] = 0; m_fl[k] = 0; m_res[k] = -10; m_idle[k] = c + 1;
      e_tk[k] = 0; m_tc[k] = 0; m_nc[k] = 0;
      return;
    end
    rdy_now = model_ready(k, c);
    if (m_fl[k] > 0) m_fl[k]--;
    if (m_redir[k] && redirect_ready) begin
      m_redir[k] = 0;
      m_fl[k] = flush_len[k];
    end
    if (c == m_res[k]) begin
      if (e_tk[k]) m_tc[k] = (m_tc[k] < cnt_max[k]) ? m_tc[k] + 1 : m_tc[k];
      else         m_nc[k] = (m_nc[k] < cnt_max[k]) ? m_nc[k] + 1 : m_nc[k];
    end
    if (c + 1 == m_res[k] && e_tk[k]) begin
      m_redir[k] = 1;
      m_rpc[k] = e_tgt[k];
    end
    if (rdy_now && br_valid) begin
      lgl = 1;
      case (fu_3)
        3'd0: cnd = (op1 == op2);
        3'd1: cnd = (op1 != op2);
        3'd4: cnd = ($signed(op1) <  $signed(op2));
        3'd5: cnd = ($signed(op1) >= $signed(op2));
        3'd6: cnd = (op1 <  op2);
        3'd7: cnd = (op1 >= op2);
        default: begin cnd = 0; lgl = 0; end
      endcase
      t = pc + imm;
      e_il[k]  = !lgl;
      e_mi[k]  = lgl && cnd && (t % 4 != 0);
      e_tk[k]  = lgl && cnd && (t % 4 == 0);
      e_tgt[k] = t;
      m_res[k] = c + 2;
      m_idle[k] = c + 2;
    end
  endtask

  task automatic check_inst(input int k, input int c);
    logic [31:0] rpc, tc, nc;
    bit          rv;
    string       p;
    p   = $sformatf("u%0d.", k);
    rpc = (k == 0) ? rpc0 : (k == 1) ? rpc1 : rpc2;
    tc  = (k == 0) ? {16'd0, tc0} : (k == 1) ? {30'd0, tc1} : {16'd0, tc2};
    nc  = (k == 0) ? {16'd0, nc0} : (k == 1) ? {30'd0, nc1} : {16'd0, nc2};
    rv  = (c == m_res[k]);
    check_eq({p, "br_ready"},       32'(rdy_o[k]), 32'(model_ready(k, c)));
    check_eq({p, "resolve_valid"},  32'(rv_o[k]),  32'(rv));
    check_eq({p, "illegal"},        32'(ill_o[k]), 32'(rv && e_il[k]));
    check_eq({p, "misalign"},       32'(mis_o[k]), 32'(rv && e_mi[k]));
    if (rv) check_eq({p, "resolve_taken"}, 32'(rt_o[k]), 32'(e_tk[k]));
    check_eq({p, "redirect_valid"}, 32'(rdv_o[k]), 32'(m_redir[k]));
    if (m_redir[k]) check_eq({p, "redirect_pc"}, rpc, m_rpc[k]);
    check_eq({p, "flush"},          32'(fl_o[k]),  32'(m_fl[k] > 0));
    check_eq({p, "taken_cnt"},      tc, 32'(m_tc[k]));
    check_eq({p, "nt_cnt"},         nc, 32'(m_nc[k]));
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Directed requests: {fu_3, op1, op2, pc, imm}
  localparam int ND = 8;
  localparam int WIN = 12;
  logic [2:0]  d_f[ND]  = '{3'd0, 3'd4, 3'd6, 3'd1, 3'd2, 3'd5, 3'd0, 3'd7};
  logic [31:0] d_a[ND]  = '{32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,
                            32'h3, 32'h5, 32'h7, 32'h0};
  logic [31:0] d_b[ND]  = '{32'h5, 32'h1, 32'h1, 32'h2,
                            32'h3, 32'h1, 32'h7, 32'h1};
  logic [31:0] d_pc[ND] = '{32'h100, 32'h200, 32'h200, 32'h300,
                            32'h400, 32'h100, 32'h500, 32'h600};
  logic [31:0] d_im[ND] = '{32'h20, 32'h40, 32'h40, 32'h10,
                            32'h8, 32'h6, 32'h20, 32'h8};

  task automatic drive(input int c);
    int idx, off;
    logic [31:0] r;
    if (c < 2) begin
      rst_n = 0; br_valid = 0; fu_3 = '0; op1 = '0; op2 = '0;
      pc = '0; imm = '0; redirect_ready = 0;
    end else if (c < 2 + ND * WIN) begin
      idx = (c - 2) / WIN;
      off = (c - 2) % WIN;
      rst_n    = !(idx == 6 && off == 4);
      br_valid = (off == 0);
      fu_3 = d_f[idx]; op1 = d_a[idx]; op2 = d_b[idx];
      pc = d_pc[idx]; imm = d_im[idx];
      redirect_ready = (idx == 3) ? (off >= 7) : 1'b1;
    end else begin
      rst_n    = ($urandom_range(0, 199) != 0);
      br_valid = ($urandom_range(0, 9) < 7);
      fu_3     = 3'($urandom_range(0, 7));
      op1      = pick_op();
      op2      = ($urandom_range(0, 2) == 0) ? op1 : pick_op();
      pc       = $urandom & 32'hFFFF_FFFC;
      r        = $urandom;
      imm      = {{20{r[11]}}, r[11:0]};
      imm      = ($urandom_range(0, 3) == 0) ? (imm & 32'hFFFF_FFFE)
                                             : (imm & 32'hFFFF_FFFC);
      redirect_ready = ($urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    rst_n = 0; br_valid = 0; fu_3 = '0; op1 = '0; op2 = '0;
    pc = '0; imm = '0; redirect_ready = 0;
    for (int c = 0; c < 2 + ND * WIN + 3000; c++) begin
      @(negedge clk);
      cyc = c;
      if (model_on)
        for (int k = 0; k < 3; k++) check_inst(k, c);
      drive(c);
      for (int k = 0; k < 3; k++) model_step(k, c);
      if (!rst_n) model_on = 1'b1;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
